// File: rtl/mult_seq.sv
// Multi-cycle radix-2 shift-add multiplier (MULT/MULTU) with start/busy/done
// handshake, flush abort and Z/V/S/C flags over the full product.
module mult_seq #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      signed_mode,
    input  logic                      flush,
    input  logic [DATA_WIDTH-1:0]     input1,
    input  logic [DATA_WIDTH-1:0]     input2,
    output logic                      busy,
    output logic                      done,
    output logic [2*DATA_WIDTH-1:0]   dataOut,
    output logic                      C,
    output logic                      Z,
    output logic                      V,
    output logic                      S
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               state;
    logic [W-1:0]         mcand;
    logic [W-1:0]         acc;
    logic [W-1:0]         mplier;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 neg;
    logic                 sgn;

    logic [W-1:0]         mag1_c;
    logic [W-1:0]         mag2_c;
    logic [W:0]           sum_c;
    logic [PW-1:0]        prod_c;
    logic [PW-1:0]        res_c;
    logic [W:0]           top_c;
    logic                 z_c;
    logic                 v_c;

    // Operand magnitudes; most-negative maps to 2^(W-1) as an unsigned value
    always_comb begin
        mag1_c = input1;
        mag2_c = input2;
        if (signed_mode && input1[W-1]) mag1_c = W'(-input1);
        if (signed_mode && input2[W-1]) mag2_c = W'(-input2);
    end

    // One shift-add step: conditional add into the upper half, carry kept
    always_comb begin
        sum_c = {1'b0, acc};
        if (mplier[0]) sum_c = {1'b0, acc} + {1'b0, mcand};
    end

    // Final sign fix-up and flags over the full product
    always_comb begin
        prod_c = {acc, mplier};
        res_c  = neg ? PW'(-prod_c) : prod_c;
        top_c  = res_c[PW-1:W-1];
        z_c    = (res_c == '0);
        if (sgn) v_c = !((top_c == '0) || (top_c == '1));
        else     v_c = (res_c[PW-1:W] != '0);
    end

    assign C = 1'b0;

    // Control FSM and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mcand   <= '0;
            acc     <= '0;
            mplier  <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            sgn     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dataOut <= '0;
            Z       <= 1'b0;
            V       <= 1'b0;
            S       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        mcand  <= mag1_c;
                        mplier <= mag2_c;
                        acc    <= '0;
                        cnt    <= '0;
                        neg    <= signed_mode & (input1[W-1] ^ input2[W-1]);
                        sgn    <= signed_mode;
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        acc    <= sum_c[W:1];
                        mplier <= {sum_c[0], mplier[W-1:1]};
                        cnt    <= cnt + CNT_WIDTH'(1);
                        if (cnt == LAST_CNT) state <= FIX;
                    end
                end
                FIX: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (!flush) begin
                        dataOut <= res_c;
                        Z       <= z_c;
                        V       <= v_c;
                        S       <= res_c[PW-1];
                        done    <= 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mult_seq.md
Name: mult_seq

Overview:
- Multi-cycle, parametrised signed/unsigned integer multiplier for the execute stage. It serves MULT and MULTU and writes the HI/LO pair.
- Replaces the single-cycle combinational multiplier with a radix-2 shift-add datapath.
- Uses a start/busy/done handshake so the pipeline stalls while the operation is in progress.
- Adds signed mode, a pipeline flush, and corrected Z/V flags computed over the full product.

Parameters:
- DATA_WIDTH, 32: operand width. Product is 2*DATA_WIDTH. Legal values are 4 to 64.
- CNT_WIDTH, 6: iteration counter width. Must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: request. Sampled only when busy=0.
- signed_mode, input, 1: 1 = two's-complement (MULT), 0 = unsigned (MULTU). Sampled with start.
- flush, input, 1: synchronous abort of an in-flight operation.
- input1, input, DATA_WIDTH: multiplicand. Sampled with start.
- input2, input, DATA_WIDTH: multiplier. Sampled with start.
- busy, output, 1: operation in progress.
- done, output, 1: one-cycle pulse when the result is valid.
- dataOut, output, 2*DATA_WIDTH: product. {HI, LO} = {upper, lower} halves.
- C, output, 1: carry flag. Always 0.
- Z, output, 1: full 2*DATA_WIDTH product equals 0.
- V, output, 1: product does not fit in DATA_WIDTH bits.
- S, output, 1: dataOut[2*DATA_WIDTH-1].

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - busy=0, done=0, dataOut=0, C=0, Z=0, V=0, S=0.
  - Counter and internal registers cleared.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 at an edge latches the operands and signed_mode, then goes to CALC.
  - busy=1 from the next cycle.
  - In signed_mode, each operand is converted to its magnitude and neg = input1[MSB] XOR input2[MSB] is recorded.
- CALC:
  - Runs exactly DATA_WIDTH cycles.
  - Each cycle: if multiplier LSB=1, add the multiplicand into the upper half of the accumulator (DATA_WIDTH+1-bit add, carry kept). Then shift the {accumulator, multiplier} register right by 1.
  - Counter runs 0 to DATA_WIDTH-1. Leaves to FIX when counter = DATA_WIDTH-1.
- FIX (1 cycle):
  - If signed_mode and neg, the product is two's-complement negated.
  - Registers dataOut and all flags.
  - Returns to IDLE.
- Done timing: done=1 and busy=0 in the cycle immediately after FIX. Total latency from the accepting edge to the done-high cycle is DATA_WIDTH+1 edges (33 at default).
- done is high for exactly one cycle.
- dataOut and flags hold their values until the next successful completion.
- start=1 during the done cycle is accepted (back-to-back issue). The next result arrives DATA_WIDTH+1 edges later.
- start while busy=1 is ignored, with no queueing.
- Flags are computed on the final 2*DATA_WIDTH product P:
  - Z = (P == 0).
  - S = P[MSB].
  - V, signed: P[2W-1:W-1] is not all-0s and not all-1s.
  - V, unsigned: P[2W-1:W] != 0.
  - C = 0.
- Signed edge case: most-negative x most-negative (e.g. 0x80000000^2) gives 0x4000000000000000, with V=1 and S=0. The magnitude path uses an unsigned DATA_WIDTH-bit magnitude, so no overflow occurs internally.
- flush:
  - flush=1 at an edge with state CALC or FIX returns to IDLE.
  - busy=0 next cycle. No done pulse. dataOut and flags are unchanged.
  - flush in IDLE has no effect. flush has priority over start in the same cycle.
- Reset mid-operation aborts immediately and clears everything. No done pulse on release.
- Outputs are registered. There is no combinational path from inputs to outputs.

Test Plan:
- Reset, then unsigned 7 x 6: done exactly 33 edges after start, dataOut=0x2A, Z=0, V=0, S=0.
- Signed -3 (0xFFFFFFFD) x 5: dataOut=0xFFFFFFFFFFFFFFF1, S=1, V=0. Unsigned with the same operands: dataOut=0x00000004FFFFFFF1, V=1, S=0.
- 0x80000000 x 0x80000000: signed gives 0x4000000000000000, V=1. Then 0 x 0x12345678 gives dataOut=0, Z=1, V=0.
- Back-to-back: start held during the done cycle is accepted. Second done arrives 33 edges later, with exactly one done pulse per op. start pulses while busy are ignored.
- flush at CALC cycle 10: busy drops the next cycle, no done, and dataOut keeps the previous result. rst_n low at cycle 20 of a new op clears all outputs asynchronously.
- Randomised sweep at DATA_WIDTH=8 and 32: every done result matches a reference model for all flags in both modes.
